// File: rtl/oob_loader.sv
// Byte-stream program loader: framed bytes in, 32-bit oob memory writes out.
// Holds the processor in reset until a frame has been fully written.
module oob_loader #(
  parameter int unsigned MAX_WORDS = 65536,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        restart,
  output logic [31:0] oob_wr_addr,
  output logic [31:0] oob_wr_data,
  output logic        oob_wen,
  output logic        proc_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

  state_t      state;
  state_t      state_n;
  logic [1:0]  idx;
  logic [31:0] shreg;
  logic [31:0] cur_addr;
  logic [31:0] remaining;

  logic        accept;
  logic        last;
  logic        rst_ok;
  logic [31:0] word;

  // Bytes enter at the top so four shifts leave {b3,b2,b1,b0}.
  assign word   = {in_data, shreg[31:8]};
  assign accept = in_valid && in_ready;
  assign last   = accept && (idx == 2'd3);
  assign rst_ok = restart &&
                  ((state == S_DONE) || (state == S_ERR));

  always_comb begin
    in_ready  = 1'b1;
    proc_hold = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      S_DONE: begin
        in_ready  = 1'b0;
        proc_hold = 1'b0;
        done      = 1'b1;
      end
      S_ERR: begin
        in_ready = 1'b0;
        err      = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_n = S_ADDR;
      end
      S_ADDR: begin
        if (last) state_n = S_COUNT;
      end
      S_COUNT: begin
        if (last) begin
          if (word > MAX_N) state_n = S_ERR;
          else if (word == '0) state_n = S_DONE;
          else state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (last && remaining == 32'd1)
          state_n = S_DONE;
      end
      S_DONE, S_ERR: begin
        if (restart) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      shreg       <= '0;
      cur_addr    <= '0;
      remaining   <= '0;
      oob_wr_addr <= '0;
      oob_wr_data <= '0;
      oob_wen     <= 1'b0;
    end else begin
      oob_wen <= 1'b0;
      if (rst_ok) begin
        idx   <= '0;
        shreg <= '0;
      end else if (accept) begin
        idx   <= idx + 2'd1;
        shreg <= word;
        if (last) begin
          unique case (state)
            S_ADDR: begin
              cur_addr <= word & ADDR_MASK;
            end
            S_COUNT: begin
              remaining <= word;
            end
            S_DATA: begin
              oob_wr_addr <= cur_addr;
              oob_wr_data <= word;
              oob_wen     <= 1'b1;
              cur_addr    <= cur_addr + 32'd4;
              remaining   <= remaining - 32'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_oob_loader.sv
// Directed bench for oob_loader: frames, limits, wrap, reset and restart.
// A negedge monitor logs every oob write for comparison after each frame.
module tb_oob_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        restart;
  logic [31:0] oob_wr_addr;
  logic [31:0] oob_wr_data;
  logic        oob_wen;
  logic        proc_hold;
  logic        done;
  logic        err;

  int n_cmp;
  int n_err;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  oob_loader #(
    .MAX_WORDS(4),
    .ADDR_MASK(32'hFFFF_FFFC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .restart(restart),
    .oob_wr_addr(oob_wr_addr),
    .oob_wr_data(oob_wr_data),
    .oob_wen(oob_wen),
    .proc_hold(proc_hold),
    .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (oob_wen === 1'b1) begin
      wa_q.push_back(oob_wr_addr);
      wd_q.push_back(oob_wr_data);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_cmp++;
    if (oob_wen !== 1'b0 || oob_wr_addr !== 32'h0 ||
        oob_wr_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_oob: got wen=%b a=%h d=%h want 0/0/0",
               oob_wen, oob_wr_addr, oob_wr_data);
    end
    n_cmp++;
    if (proc_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: got hold=%b done=%b err=%b want 1/0/0",
               proc_hold, done, err);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] ea[2];
    logic [31:0] ed[2];
    ea = '{32'h100, 32'h104};
    ed = '{32'h12345678, 32'hDEADBEEF};
    wa_q.delete();
    wd_q.delete();
    send_word(32'h0000_0100);
    send_word(32'd2);
    send_word(32'h1234_5678);
    n_cmp++;
    if (oob_wen !== 1'b1 || done !== 1'b0 || proc_hold !== 1'b1) begin
      n_err++;
      $display("FAIL basic_mid: got wen=%b done=%b hold=%b want 1/0/1",
               oob_wen, done, proc_hold);
    end
    send_word(32'hDEAD_BEEF);
    n_cmp++;
    if (oob_wen !== 1'b1 || done !== 1'b1 || proc_hold !== 1'b0 ||
        in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic_last: got wen=%b done=%b hold=%b rdy=%b want 1/1/0/0",
               oob_wen, done, proc_hold, in_ready);
    end
    settle();
    n_cmp++;
    if (wa_q.size() != 2) begin
      n_err++;
      $display("FAIL basic_count: got %0d writes want 2", wa_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      if (wa_q.size() > i) begin
        n_cmp++;
        if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
          n_err++;
          $display("FAIL basic_w%0d: got %h/%h want %h/%h",
                   i, wa_q[i], wd_q[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_misaligned_zero();
    pulse_restart();
    wa_q.delete();
    wd_q.delete();
    send_word(32'h0000_0003);
    send_word(32'd1);
    send_word(32'hDDCC_BBAA);
    settle();
    n_cmp++;
    if (wa_q.size() != 1 || wa_q[0] !== 32'h0 ||
        wd_q[0] !== 32'hDDCCBBAA) begin
      n_err++;
      $display("FAIL misalign_w: got n=%0d %h/%h want 1 00000000/ddccbbaa",
               wa_q.size(), wa_q.size() ? wa_q[0] : 32'hx,
               wd_q.size() ? wd_q[0] : 32'hx);
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL misalign_done: got %b want 1", done);
    end
    pulse_restart();
    wa_q.delete();
    wd_q.delete();
    send_word(32'h0000_0040);
    send_word(32'd0);
    n_cmp++;
    if (done !== 1'b1 || proc_hold !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done: got done=%b hold=%b want 1/0",
               done, proc_hold);
    end
    settle();
    n_cmp++;
    if (wa_q.size() != 0) begin
      n_err++;
      $display("FAIL zero_nowrite: got %0d writes want 0", wa_q.size());
    end
  endtask

  task automatic test_overlimit();
    pulse_restart();
    wa_q.delete();
    wd_q.delete();
    send_word(32'h0000_0080);
    send_word(32'd5);
    n_cmp++;
    if (err !== 1'b1 || proc_hold !== 1'b1 || done !== 1'b0 ||
        in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL over_err: got err=%b hold=%b done=%b rdy=%b want 1/1/0/0",
               err, proc_hold, done, in_ready);
    end
    send_word(32'h1111_1111);
    settle();
    n_cmp++;
    if (wa_q.size() != 0 || err !== 1'b1) begin
      n_err++;
      $display("FAIL over_nowrite: got n=%0d err=%b want 0/1",
               wa_q.size(), err);
    end
    pulse_restart();
    n_cmp++;
    if (err !== 1'b0 || in_ready !== 1'b1 || proc_hold !== 1'b1) begin
      n_err++;
      $display("FAIL over_restart: got err=%b rdy=%b hold=%b want 0/1/1",
               err, in_ready, proc_hold);
    end
    send_word(32'h0000_0200);
    send_word(32'd4);
    for (int i = 0; i < 4; i++) send_word(32'hA000_0000 + 32'(i));
    settle();
    n_cmp++;
    if (wa_q.size() != 4 || done !== 1'b1) begin
      n_err++;
      $display("FAIL max_count: got n=%0d done=%b want 4/1",
               wa_q.size(), done);
    end
    for (int i = 0; i < 4; i++) begin
      if (wa_q.size() > i) begin
        n_cmp++;
        if (wa_q[i] !== 32'h200 + 32'(4 * i) ||
            wd_q[i] !== 32'hA000_0000 + 32'(i)) begin
          n_err++;
          $display("FAIL max_w%0d: got %h/%h want %h/%h", i,
                   wa_q[i], wd_q[i], 32'h200 + 32'(4 * i),
                   32'hA000_0000 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_wrap_stall();
    logic [31:0] ea[2];
    logic [31:0] ed[2];
    ea = '{32'hFFFF_FFFC, 32'h0000_0000};
    ed = '{32'h0102_0304, 32'hA5A5_5A5A};
    pulse_restart();
    wa_q.delete();
    wd_q.delete();
    send_word(32'hFFFF_FFFC);
    send_word(32'd2);
    for (int w = 0; w < 2; w++) begin
      for (int b = 0; b < 4; b++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        n_cmp++;
        if (oob_wen !== 1'b0) begin
          n_err++;
          $display("FAIL wrap_early%0d_%0d: got wen=%b want 0",
                   w, b, oob_wen);
        end
        send_byte(ed[w][8*b +: 8]);
      end
      n_cmp++;
      if (oob_wen !== 1'b1 || oob_wr_addr !== ea[w] ||
          oob_wr_data !== ed[w]) begin
        n_err++;
        $display("FAIL wrap_w%0d: got wen=%b %h/%h want 1 %h/%h", w,
                 oob_wen, oob_wr_addr, oob_wr_data, ea[w], ed[w]);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (oob_wen !== 1'b0) begin
        n_err++;
        $display("FAIL wrap_pulse%0d: got wen=%b want 0", w, oob_wen);
      end
    end
    n_cmp++;
    if (wa_q.size() != 2 || done !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_count: got n=%0d done=%b want 2/1",
               wa_q.size(), done);
    end
  endtask

  task automatic test_reset_mid();
    pulse_restart();
    wa_q.delete();
    wd_q.delete();
    send_word(32'h0000_0300);
    send_word(32'd2);
    send_byte(8'h0D);
    send_byte(8'hF0);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (oob_wen !== 1'b0 || oob_wr_addr !== 32'h0 ||
        oob_wr_data !== 32'h0) begin
      n_err++;
      $display("FAIL rmid_oob: got wen=%b %h/%h want 0 0/0",
               oob_wen, oob_wr_addr, oob_wr_data);
    end
    n_cmp++;
    if (proc_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_flags: got hold=%b done=%b err=%b want 1/0/0",
               proc_hold, done, err);
    end
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_word(32'h0000_0300);
    send_word(32'd1);
    send_word(32'hCAFE_F00D);
    settle();
    n_cmp++;
    if (wa_q.size() != 1 || wa_q[0] !== 32'h300 ||
        wd_q[0] !== 32'hCAFEF00D || done !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_reload: got n=%0d %h/%h done=%b want 1 300/cafef00d 1",
               wa_q.size(), wa_q.size() ? wa_q[0] : 32'hx,
               wd_q.size() ? wd_q[0] : 32'hx, done);
    end
  endtask

  task automatic test_restart_coincide();
    wa_q.delete();
    wd_q.delete();
    restart  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h08;
    @(posedge clk);
    #1;
    restart  = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || done !== 1'b0 || proc_hold !== 1'b1) begin
      n_err++;
      $display("FAIL coin_idle: got rdy=%b done=%b hold=%b want 1/0/1",
               in_ready, done, proc_hold);
    end
    send_word(32'h0000_0020);
    send_word(32'd1);
    pulse_restart();
    send_word(32'h4433_2211);
    settle();
    n_cmp++;
    if (wa_q.size() != 1 || wa_q[0] !== 32'h20 ||
        wd_q[0] !== 32'h44332211 || done !== 1'b1) begin
      n_err++;
      $display("FAIL coin_load: got n=%0d %h/%h done=%b want 1 20/44332211 1",
               wa_q.size(), wa_q.size() ? wa_q[0] : 32'hx,
               wd_q.size() ? wd_q[0] : 32'hx, done);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    restart  = 1'b0;
    test_reset();
    test_basic();
    test_misaligned_zero();
    test_overlimit();
    test_wrap_stall();
    test_reset_mid();
    test_restart_coincide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/oob_loader.md
Name: oob_loader

Overview:
- Byte-stream program loader. It is the initiator (writer) side of the out-of-band memory write port: oob_wr_addr, oob_wr_data, oob_wen.
- Accepts a framed byte stream (header, then payload) from a host-side source, e.g. a UART receiver or testbench.
- Assembles little-endian 32-bit words and issues one single-cycle oob write per word at auto-incrementing addresses.
- Holds the processor in reset until the load completes.

Parameters:
- MAX_WORDS, 65536: largest word count accepted. A larger count sets err.
- ADDR_MASK, 32'hFFFF_FFFC: ANDed with the received start address; alignment is forced.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready at a clk edge.
- restart  input  1  single-cycle pulse: leave DONE/ERR and return to IDLE.
- oob_wr_addr  output  32  write address, registered.
- oob_wr_data  output  32  write data, registered.
- oob_wen  output  1  one-cycle write strobe, registered.
- proc_hold  output  1  high while a load is pending or in progress; external logic keeps the processor in reset while it is high.
- done  output  1  level: the last load completed successfully.
- err  output  1  level: frame rejected (count > MAX_WORDS).

Behaviour:
Reset (rst low, asynchronous; it takes effect mid-frame with no partial write):
- state = IDLE, byte index = 0, all shift and count registers = 0.
- oob_wr_addr = 0, oob_wr_data = 0, oob_wen = 0.
- proc_hold = 1, done = 0, err = 0.

Frame format, all fields little-endian:
- 4 bytes: start address.
- 4 bytes: word count N.
- N x 4 bytes: data words.

States:
- IDLE: in_ready = 1. The first accepted byte becomes address byte 0; go to ADDR.
- ADDR: collect address bytes 1..3. On byte 3:
  - cur_addr = {b3,b2,b1,b0} & ADDR_MASK.
  - Go to COUNT.
- COUNT: collect 4 bytes. On byte 3, with N = {b3,b2,b1,b0}:
  - N > MAX_WORDS: go to ERR, err = 1.
  - N == 0: go to DONE.
  - Otherwise: remaining = N, go to DATA.
- DATA: shift bytes into the word register. On the edge that accepts byte 3 of a word:
  - Next cycle: oob_wr_data = assembled word, oob_wr_addr = cur_addr, oob_wen = 1 for exactly that one cycle.
  - cur_addr += 4 (wraps modulo 2^32).
  - remaining -= 1.
  - If remaining reaches 0, go to DONE; this transition happens in the same edge as the oob_wen set.
- DONE: in_ready = 0, proc_hold = 0, done = 1. Stay until restart.
- ERR: in_ready = 0, proc_hold = 1, err = 1. Stay until restart. No further writes.

restart:
- Honoured in DONE or ERR: next state IDLE, done = 0, err = 0, proc_hold = 1, byte index = 0.
- Ignored in IDLE/ADDR/COUNT/DATA.
- If restart and in_valid coincide in DONE, the byte is not accepted (in_ready = 0 that cycle).

Timing:
- in_ready is 1 in IDLE/ADDR/COUNT/DATA every cycle. There is no backpressure, because oob writes always complete in one cycle.
- Back-to-back bytes give at most one oob_wen per 4 cycles. Gaps in in_valid simply stall assembly.
- Latency: the final byte of a word is accepted at edge k; oob_wen is high in cycle k+1.
- For the last word, done and proc_hold = 0 become visible in the same cycle as its oob_wen.
- in_data is ignored whenever in_valid = 0.

Test Plan:
- Basic load:
  - Stimulus: after reset, stream address 00 01 00 00, count 02 00 00 00, data 78 56 34 12 EF BE AD DE.
  - Required: two oob_wen pulses: (0x00000100, 0x12345678) then (0x00000104, 0xDEADBEEF). Then done = 1, proc_hold = 0, in_ready = 0.
- Misaligned address, zero count:
  - Stimulus: address 03 00 00 00 with N = 1, data AA BB CC DD. Separately, a frame with N = 0.
  - Required: write at 0x00000000 with data 0xDDCCBBAA. The N = 0 frame reaches done with no oob_wen.
- Over-limit count:
  - Stimulus: MAX_WORDS = 4, count 05 00 00 00.
  - Required: err = 1, proc_hold = 1, no oob_wen. After restart: err = 0, state IDLE, and a following valid frame loads correctly.
- Stalled stream, address wrap:
  - Stimulus: address FC FF FF FF, N = 2, with random in_valid gaps.
  - Required: writes at 0xFFFFFFFC then 0x00000000. Each oob_wen is exactly 1 cycle, 1 cycle after the word's 4th byte.
- Reset mid-frame:
  - Stimulus: assert rst after 2 data bytes of the first word.
  - Required: outputs clear immediately (asynchronous), no oob_wen, proc_hold = 1. A full frame afterwards loads from scratch.
- restart/in_valid coincidence:
  - Stimulus: in DONE, pulse restart while in_valid = 1.
  - Required: that byte is not consumed; the next byte is taken as address byte 0.
